// File: rtl/traffic_pkg.sv
// Shared encodings for the junction controller: phase states, lamp patterns
// and the state-to-lamp decode used to build the registered lamp outputs.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED1  = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    RED2  = 3'd5,
    FLASH = 3'd6
  } state_t;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Returns {ns, ew}; anything not explicitly lit falls back to all-red.
  function automatic logic [5:0] lamps(input state_t s, input logic fl);
    case (s)
      NS_G:    lamps = {LAMP_G, LAMP_R};
      NS_Y:    lamps = {LAMP_Y, LAMP_R};
      EW_G:    lamps = {LAMP_R, LAMP_G};
      EW_Y:    lamps = {LAMP_R, LAMP_Y};
      FLASH:   lamps = fl ? {LAMP_Y, LAMP_Y} : {LAMP_OFF, LAMP_OFF};
      default: lamps = {LAMP_R, LAMP_R};
    endcase
  endfunction

endpackage

// File: rtl/sec_strobe.sv
// Resynchronises an asynchronous slow square wave and emits a one-clock
// strobe per rising edge; falling edges produce nothing.
module sec_strobe (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_hz,
  output logic sec_pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_hz;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s1 is the metastability catcher; edge detect only on settled flops.
  assign sec_pulse = s2 & ~s3;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road junction sequencer stepped by a seconds strobe, with a
// flashing-yellow night mode and a seconds-remaining display count.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int T_GREEN  = 25,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2,
  parameter int CNT_W    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_hz,
  input  logic             night,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [CNT_W-1:0] sec_left,
  output logic             sec_pulse
);

  localparam logic [CNT_W-1:0] LD_G = CNT_W'(T_GREEN);
  localparam logic [CNT_W-1:0] LD_Y = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] LD_R = CNT_W'(T_ALLRED);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt_n;
  logic             flash, flash_n;
  logic [2:0]       ns_n, ew_n;

  sec_strobe u_strobe (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_hz    (clk_hz),
    .sec_pulse (sec_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RED1;
      sec_left <= LD_R;
      flash    <= 1'b0;
      ns_light <= LAMP_R;
      ew_light <= LAMP_R;
    end else begin
      state    <= state_n;
      sec_left <= cnt_n;
      flash    <= flash_n;
      ns_light <= ns_n;
      ew_light <= ew_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = sec_left;
    flash_n = flash;
    case (state)
      NS_G, NS_Y, RED1, EW_G, EW_Y, RED2: begin
        if (sec_pulse) begin
          // Night request wins over a phase expiring on the same strobe.
          if (night) begin
            state_n = FLASH;
            cnt_n   = '0;
            flash_n = 1'b1;
          end else if (sec_left > CNT_W'(1)) begin
            cnt_n = sec_left - CNT_W'(1);
          end else begin
            case (state)
              RED1:    begin state_n = NS_G; cnt_n = LD_G; end
              NS_G:    begin state_n = NS_Y; cnt_n = LD_Y; end
              NS_Y:    begin state_n = RED2; cnt_n = LD_R; end
              RED2:    begin state_n = EW_G; cnt_n = LD_G; end
              EW_G:    begin state_n = EW_Y; cnt_n = LD_Y; end
              default: begin state_n = RED1; cnt_n = LD_R; end
            endcase
          end
        end
      end
      FLASH: begin
        if (sec_pulse) begin
          if (night) begin
            flash_n = ~flash;
          end else begin
            state_n = RED2;
            cnt_n   = LD_R;
            flash_n = 1'b0;
          end
        end
      end
      default: begin
        // Corrupted encoding: recover immediately, not waiting for a strobe.
        state_n = RED1;
        cnt_n   = LD_R;
        flash_n = 1'b0;
      end
    endcase
    {ns_n, ew_n} = lamps(state_n, flash_n);
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with short phase timings and a
// directly driven clk_hz; expected lamp/count values are hand-computed.
module tb_traffic_light_ctrl;

  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clk_hz = 1'b0;
  logic             night = 1'b0;
  logic [2:0]       ns_light, ew_light;
  logic [CNT_W-1:0] sec_left;
  logic             sec_pulse;

  int n_vec = 0;
  int n_err = 0;

  traffic_light_ctrl #(
    .T_GREEN  (5),
    .T_YELLOW (2),
    .T_ALLRED (1),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_hz    (clk_hz),
    .night     (night),
    .ns_light  (ns_light),
    .ew_light  (ew_light),
    .sec_left  (sec_left),
    .sec_pulse (sec_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] ens, input logic [2:0] eew,
                         input int esec);
    chk({tag, ".ns"},  32'(ns_light), 32'(ens));
    chk({tag, ".ew"},  32'(ew_light), 32'(eew));
    chk({tag, ".sec"}, 32'(sec_left), 32'(esec));
  endtask

  // One full clk_hz period; the strobe must fire exactly once inside it.
  task automatic tick(input string tag);
    int npulse = 0;
    @(negedge clk);
    clk_hz = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (sec_pulse) npulse++;
    end
    @(negedge clk);
    clk_hz = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (sec_pulse) npulse++;
    end
    chk({tag, ".npulse"}, 32'(npulse), 32'd1);
  endtask

  logic [2:0] e_ns  [0:16];
  logic [2:0] e_ew  [0:16];
  int         e_sec [0:16];

  initial begin
    int np;
    e_ns  = '{3'b001,3'b001,3'b001,3'b001,3'b001,3'b010,3'b010,3'b100,
              3'b100,3'b100,3'b100,3'b100,3'b100,3'b100,3'b100,3'b100,3'b001};
    e_ew  = '{3'b100,3'b100,3'b100,3'b100,3'b100,3'b100,3'b100,3'b100,
              3'b001,3'b001,3'b001,3'b001,3'b001,3'b010,3'b010,3'b100,3'b100};
    e_sec = '{5,4,3,2,1,2,1,1,5,4,3,2,1,2,1,1,5};

    // Reset values, then held with no clk_hz activity.
    repeat (3) @(posedge clk);
    #1;
    chk_out("rst", 3'b100, 3'b100, 1);
    chk("rst.pulse", 32'(sec_pulse), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    np = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (sec_pulse) np++;
    end
    chk_out("idle", 3'b100, 3'b100, 1);
    chk("idle.npulse", 32'(np), 32'd0);

    // First strobe timing: high only after the second edge following the rise.
    @(negedge clk);
    clk_hz = 1'b1;
    @(posedge clk); #1;
    chk("edge1.pulse", 32'(sec_pulse), 32'd0);
    chk_out("edge1", 3'b100, 3'b100, 1);
    @(posedge clk); #1;
    chk("edge2.pulse", 32'(sec_pulse), 32'd1);
    chk_out("edge2", 3'b100, 3'b100, 1);
    @(posedge clk); #1;
    chk("edge3.pulse", 32'(sec_pulse), 32'd0);
    chk_out("p1", e_ns[0], e_ew[0], e_sec[0]);
    np = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (sec_pulse) np++;
    end
    @(negedge clk);
    clk_hz = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (sec_pulse) np++;
    end
    chk("high_fall.npulse", 32'(np), 32'd0);
    chk_out("p1_hold", e_ns[0], e_ew[0], e_sec[0]);

    // Remaining pulses of one full 16-pulse period plus the wrap into NS_G.
    for (int i = 1; i < 17; i++) begin
      tick($sformatf("p%0d", i + 1));
      chk_out($sformatf("p%0d", i + 1), e_ns[i], e_ew[i], e_sec[i]);
    end

    // Advance NS_G(5) -> EW_G(5): 8 pulses.
    repeat (8) tick("adv");
    chk_out("ewg", 3'b100, 3'b001, 5);

    // night wiggle with no strobe must not move the FSM.
    @(negedge clk); night = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); night = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk_out("night_nopulse", 3'b100, 3'b001, 5);

    night = 1'b1;
    tick("fl1"); chk_out("fl1", 3'b010, 3'b010, 0);
    tick("fl2"); chk_out("fl2", 3'b000, 3'b000, 0);
    tick("fl3"); chk_out("fl3", 3'b010, 3'b010, 0);
    night = 1'b0;
    tick("unfl"); chk_out("unfl", 3'b100, 3'b100, 1);
    tick("unfl_ewg"); chk_out("unfl_ewg", 3'b100, 3'b001, 5);

    // Night beats an expiring phase on the same strobe.
    repeat (4) tick("to1");
    chk_out("ewg1", 3'b100, 3'b001, 1);
    night = 1'b1;
    tick("prio"); chk_out("prio", 3'b010, 3'b010, 0);
    night = 1'b0;
    tick("prio_out"); chk_out("prio_out", 3'b100, 3'b100, 1);

    // RED2 -> NS_Y(2) is 14 pulses.
    repeat (14) tick("to_nsy");
    chk_out("nsy", 3'b010, 3'b100, 2);

    // Async reset between clock edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 3'b100, 3'b100, 1);
    chk("async_rst.pulse", 32'(sec_pulse), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick("restart");
    chk_out("restart", 3'b001, 3'b100, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
